// File: rtl/cop0_excp_ctrl_pkg.sv
// Shared constants for the coprocessor-0 exception sequencer: cause codes,
// FSM state encoding and the vector address helper.
package cop0_excp_ctrl_pkg;

  localparam int CPU_CAUSE_W   = 5;
  localparam int CPU_VEC_W     = 32;
  localparam int CPU_IVT_W     = 22;
  localparam int CPU_IVT_ALIGN = 10;

  localparam logic [CPU_CAUSE_W-1:0] CPU_EXC_INT = 5'd0;
  localparam logic [CPU_CAUSE_W-1:0] CPU_EXC_SYS = 5'd8;
  localparam logic [CPU_CAUSE_W-1:0] CPU_EXC_BRK = 5'd9;
  localparam logic [CPU_CAUSE_W-1:0] CPU_EXC_RI  = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  // The cause offset stays below 1 KiB, so the add never disturbs the IVT bits.
  function automatic logic [CPU_VEC_W-1:0] vec_addr(
    input logic [CPU_IVT_W-1:0]   ivt,
    input logic [CPU_CAUSE_W-1:0] cause,
    input int                     shift
  );
    logic [CPU_VEC_W-1:0] base;
    logic [CPU_VEC_W-1:0] offs;
    base = {ivt, {CPU_IVT_ALIGN{1'b0}}};
    offs = CPU_VEC_W'(cause) << shift;
    return base + offs;
  endfunction

endpackage

// File: rtl/cop0_excp_ctrl_excp_prio.sv
// Combinational arbiter: picks the highest-priority pending event for p3
// and reports whether anything is to be taken.
import cop0_excp_ctrl_pkg::*;

module excp_prio (
  input  logic                   i_valid,
  input  logic                   i_ri,
  input  logic                   i_sys,
  input  logic                   i_brk,
  input  logic                   i_irq,
  input  logic                   i_ie,
  output logic                   o_take,
  output logic [CPU_CAUSE_W-1:0] o_cause
);

  logic irq_en;

  assign irq_en = i_irq & i_ie;

  // Interrupts also need a valid p3 so the saved EPC names a real instruction.
  always_comb begin
    o_take  = 1'b0;
    o_cause = CPU_EXC_INT;
    if (i_valid) begin
      if (i_ri) begin
        o_take  = 1'b1;
        o_cause = CPU_EXC_RI;
      end else if (i_sys) begin
        o_take  = 1'b1;
        o_cause = CPU_EXC_SYS;
      end else if (i_brk) begin
        o_take  = 1'b1;
        o_cause = CPU_EXC_BRK;
      end else if (irq_en) begin
        o_take  = 1'b1;
        o_cause = CPU_EXC_INT;
      end
    end
  end

endmodule

// File: rtl/cop0_excp_ctrl.sv
// Exception/interrupt sequencer: detects in IDLE, pulses the flush and
// CP0 save strobes for one cycle, then holds the fetch redirect until acked.
import cop0_excp_ctrl_pkg::*;

module cop0_excp_ctrl #(
  parameter int VEC_SHIFT = 3
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_core_stall,
  input  logic [31:0]            i_pc_p3,
  input  logic                   i_bd_p3,
  input  logic                   i_valid_p3,
  input  logic                   i_ri_p3,
  input  logic                   i_sys_p3,
  input  logic                   i_brk_p3,
  input  logic                   i_irq,
  input  logic                   i_sr_ie,
  input  logic [CPU_IVT_W-1:0]   i_ivt,
  input  logic                   i_redir_ack,
  output logic                   o_drop_p1,
  output logic                   o_drop_p2,
  output logic                   o_drop_p3,
  output logic                   o_epc_we,
  output logic [31:0]            o_epc,
  output logic                   o_ie_save,
  output logic                   o_redir,
  output logic [CPU_VEC_W-1:0]   o_redir_addr,
  output logic [CPU_CAUSE_W-1:0] o_cause,
  output logic                   o_busy
);

  state_t                   state;
  logic                     take;
  logic [CPU_CAUSE_W-1:0]   prio_cause;
  logic [31:0]              epc_next;
  logic                     drop;
  logic                     epc_we;
  logic                     ie_save;
  logic                     redir;
  logic                     busy;
  logic [31:0]              epc;
  logic [CPU_VEC_W-1:0]     redir_addr;
  logic [CPU_CAUSE_W-1:0]   cause;

  excp_prio u_prio (
    .i_valid (i_valid_p3),
    .i_ri    (i_ri_p3),
    .i_sys   (i_sys_p3),
    .i_brk   (i_brk_p3),
    .i_irq   (i_irq),
    .i_ie    (i_sr_ie),
    .o_take  (take),
    .o_cause (prio_cause)
  );

  // A delay-slot instruction restarts at its branch; wraps below address 0.
  assign epc_next = i_bd_p3 ? (i_pc_p3 - 32'd4) : i_pc_p3;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      drop       <= 1'b0;
      epc_we     <= 1'b0;
      ie_save    <= 1'b0;
      redir      <= 1'b0;
      busy       <= 1'b0;
      epc        <= '0;
      redir_addr <= '0;
      cause      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!i_core_stall && take) begin
            cause      <= prio_cause;
            epc        <= epc_next;
            redir_addr <= vec_addr(i_ivt, prio_cause, VEC_SHIFT);
            drop       <= 1'b1;
            epc_we     <= 1'b1;
            ie_save    <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_FLUSH;
          end
        end
        // Flush lasts exactly one cycle; stalls and acks have no effect here.
        ST_FLUSH: begin
          drop    <= 1'b0;
          epc_we  <= 1'b0;
          ie_save <= 1'b0;
          redir   <= 1'b1;
          state   <= ST_REDIR;
        end
        ST_REDIR: begin
          if (i_redir_ack) begin
            redir <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          drop    <= 1'b0;
          epc_we  <= 1'b0;
          ie_save <= 1'b0;
          redir   <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_drop_p1    = drop;
  assign o_drop_p2    = drop;
  assign o_drop_p3    = drop;
  assign o_epc_we     = epc_we;
  assign o_epc        = epc;
  assign o_ie_save    = ie_save;
  assign o_redir      = redir;
  assign o_redir_addr = redir_addr;
  assign o_cause      = cause;
  assign o_busy       = busy;

endmodule

// File: tb/tb_cop0_excp_ctrl.sv
// Directed bench for cop0_excp_ctrl: expected sequences are queued when an
// event is driven and checked when the flush pulse appears.
module tb_cop0_excp_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        core_stall;
  logic [31:0] pc_p3;
  logic        bd_p3, valid_p3, ri_p3, sys_p3, brk_p3;
  logic        irq, sr_ie;
  logic [21:0] ivt;
  logic        redir_ack;
  logic        drop_p1, drop_p2, drop_p3, epc_we, ie_save, redir, busy;
  logic [31:0] epc, redir_addr;
  logic [4:0]  cause;

  typedef struct {
    logic [31:0] epc;
    logic [31:0] addr;
    logic [4:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  cop0_excp_ctrl #(.VEC_SHIFT(3)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_core_stall (core_stall),
    .i_pc_p3      (pc_p3),
    .i_bd_p3      (bd_p3),
    .i_valid_p3   (valid_p3),
    .i_ri_p3      (ri_p3),
    .i_sys_p3     (sys_p3),
    .i_brk_p3     (brk_p3),
    .i_irq        (irq),
    .i_sr_ie      (sr_ie),
    .i_ivt        (ivt),
    .i_redir_ack  (redir_ack),
    .o_drop_p1    (drop_p1),
    .o_drop_p2    (drop_p2),
    .o_drop_p3    (drop_p3),
    .o_epc_we     (epc_we),
    .o_epc        (epc),
    .o_ie_save    (ie_save),
    .o_redir      (redir),
    .o_redir_addr (redir_addr),
    .o_cause      (cause),
    .o_busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] e_epc, input logic [31:0] e_addr, input logic [4:0] e_cause);
    exp_t e;
    e.epc   = e_epc;
    e.addr  = e_addr;
    e.cause = e_cause;
    sb.push_back(e);
  endtask

  task automatic wait_flush(input int exp_lat, input bit keep_irq);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!epc_we && n < 20);
    chk("flush_latency", 32'(n), 32'(exp_lat));
    ri_p3  = 1'b0;
    sys_p3 = 1'b0;
    brk_p3 = 1'b0;
    if (!keep_irq) irq = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("epc", epc, e.epc);
      chk("cause", 32'(cause), 32'(e.cause));
      chk("drops", 32'({drop_p1, drop_p2, drop_p3}), 32'h7);
      chk("ie_save", 32'(ie_save), 32'd1);
      chk("busy_flush", 32'(busy), 32'd1);
      @(negedge clk);
      chk("redir_on", 32'(redir), 32'd1);
      chk("redir_addr", redir_addr, e.addr);
      chk("pulses_off", 32'({drop_p1, drop_p2, drop_p3, epc_we, ie_save}), 32'd0);
    end
  endtask

  task automatic do_seq(input int exp_lat, input int ack_delay, input bit keep_irq);
    logic [31:0] addr0;
    wait_flush(exp_lat, keep_irq);
    addr0 = redir_addr;
    for (int i = 0; i < ack_delay; i++) begin
      valid_p3 = 1'b1;
      sys_p3   = 1'b1;
      ri_p3    = 1'b1;
      @(negedge clk);
      chk("redir_hold", 32'(redir), 32'd1);
      chk("redir_addr_stable", redir_addr, addr0);
    end
    sys_p3    = 1'b0;
    ri_p3     = 1'b0;
    redir_ack = 1'b1;
    @(negedge clk);
    redir_ack = 1'b0;
    chk("idle_after_ack", 32'({busy, redir}), 32'd0);
  endtask

  initial begin
    nrst = 1'b0; core_stall = 1'b0; pc_p3 = '0; bd_p3 = 1'b0; valid_p3 = 1'b0;
    ri_p3 = 1'b0; sys_p3 = 1'b0; brk_p3 = 1'b0; irq = 1'b0; sr_ie = 1'b0;
    ivt = 22'h000001; redir_ack = 1'b0;
    #2;
    chk("reset_flags", 32'({drop_p1, drop_p2, drop_p3, epc_we, ie_save, redir, busy}), 32'd0);
    chk("reset_epc", epc, 32'd0);
    chk("reset_addr", redir_addr, 32'd0);
    chk("reset_cause", 32'(cause), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Syscall
    valid_p3 = 1'b1; pc_p3 = 32'h0000_1000; sys_p3 = 1'b1;
    push_exp(32'h0000_1000, 32'h0000_0440, 5'd8);
    do_seq(1, 0, 1'b0);
    chk("cause_holds", 32'(cause), 32'd8);

    // RI + BRK + irq together, then the still-pending irq
    sr_ie = 1'b1; pc_p3 = 32'h0000_2000; ri_p3 = 1'b1; brk_p3 = 1'b1; irq = 1'b1;
    push_exp(32'h0000_2000, 32'h0000_0450, 5'd10);
    do_seq(1, 0, 1'b1);
    push_exp(32'h0000_2000, 32'h0000_0400, 5'd0);
    do_seq(1, 0, 1'b0);

    // SYS beats BRK
    pc_p3 = 32'h0000_5000; sys_p3 = 1'b1; brk_p3 = 1'b1;
    push_exp(32'h0000_5000, 32'h0000_0440, 5'd8);
    do_seq(1, 0, 1'b0);

    // Delay slot at PC 0 wraps the EPC
    ivt = 22'h2AAAAA; bd_p3 = 1'b1; pc_p3 = 32'h0000_0000; irq = 1'b1;
    push_exp(32'hFFFF_FFFC, 32'hAAAA_A800, 5'd0);
    do_seq(1, 0, 1'b0);
    bd_p3 = 1'b0; ivt = 22'h000001;

    // IE gating
    sr_ie = 1'b0; irq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ie_gate_idle", 32'({busy, epc_we}), 32'd0);
    end
    irq = 1'b0; sr_ie = 1'b1;

    // Invalid p3 ignores flags
    valid_p3 = 1'b0; sys_p3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("invalid_idle", 32'(busy), 32'd0);
    end
    sys_p3 = 1'b0; valid_p3 = 1'b1;

    // Stall holds off detection for 3 cycles
    ivt = 22'h000003; bd_p3 = 1'b1; pc_p3 = 32'h0000_3004;
    core_stall = 1'b1; irq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_idle", 32'(busy), 32'd0);
    end
    core_stall = 1'b0;
    push_exp(32'h0000_3000, 32'h0000_0C00, 5'd0);
    do_seq(1, 0, 1'b0);
    bd_p3 = 1'b0; ivt = 22'h000001;

    // Ack withheld 5 cycles with new flags asserted meanwhile
    pc_p3 = 32'h0000_4000; brk_p3 = 1'b1;
    push_exp(32'h0000_4000, 32'h0000_0448, 5'd9);
    do_seq(1, 5, 1'b0);
    @(negedge clk);
    chk("masked_flags_dropped", 32'(busy), 32'd0);
    chk("cause_after_mask", 32'(cause), 32'd9);

    // Async reset during REDIR
    pc_p3 = 32'h0000_6008; ri_p3 = 1'b1;
    push_exp(32'h0000_6008, 32'h0000_0450, 5'd10);
    wait_flush(1, 1'b0);
    #2 nrst = 1'b0;
    #1;
    chk("rst_mid_flags", 32'({drop_p1, drop_p2, drop_p3, epc_we, ie_save, redir, busy}), 32'd0);
    chk("rst_mid_epc", epc, 32'd0);
    chk("rst_mid_addr", redir_addr, 32'd0);
    chk("rst_mid_cause", 32'(cause), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 32'({busy, redir}), 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cop0_excp_ctrl.md
# cop0_excp_ctrl

Exception and interrupt sequencer for coprocessor 0. It arbitrates between synchronous exceptions reported from the memory stage (p3) and the external interrupt line, then drives the pipeline drop signals. It issues the EPC/IE-save write pulses that coprocessor 0 applies, and redirects fetch to the vector derived from IVT. It sits beside the control unit and coprocessor 0, and it owns the `i_drop_p*` inputs of every stage.

## Interface
- `VEC_SHIFT`, default 3 — log2 of the vector slot size in bytes; vector = {ivt[21:0], 10'b0} + (cause << VEC_SHIFT).
- `clk` in 1 — core clock.
- `nrst` in 1 — asynchronous, active-low reset.
- `i_core_stall` in 1 — OR of the exec, mem and fetch stalls.
- `i_pc_p3` in 32 — PC of the instruction in the memory stage.
- `i_bd_p3` in 1 — the p3 instruction sits in a branch delay slot.
- `i_valid_p3` in 1 — p3 holds a real (non-dropped) instruction.
- `i_ri_p3` / `i_sys_p3` / `i_brk_p3` in 1 each — reserved instruction, syscall and break flags for p3.
- `i_irq` in 1 — external interrupt, level-sensitive.
- `i_sr_ie` in 1 — current SR.IE from coprocessor 0.
- `i_ivt` in 22 — high 22 bits of the IVT base.
- `i_redir_ack` in 1 — fetch unit accepted the redirect.
- `o_drop_p1` / `o_drop_p2` / `o_drop_p3` out 1 each — flush the corresponding stage.
- `o_epc_we` out 1, `o_epc` out 32 — EPC write strobe and value.
- `o_ie_save` out 1 — coprocessor 0 does PSR.IE <= SR.IE and SR.IE <= 0.
- `o_redir` out 1, `o_redir_addr` out 32 — fetch redirect request and target.
- `o_cause` out 5 — last taken cause; holds until the next exception.
- `o_busy` out 1 — high in any state other than IDLE.

## Operation
- **States:** IDLE, FLUSH, REDIR.
- **Cause codes:** INT=0, SYS=8, BRK=9, RI=10.
- **Detection (IDLE only):** sampled on an edge with `!i_core_stall`.
  - A synchronous event needs `i_valid_p3`. Priority is RI > SYS > BRK.
  - Any synchronous event beats an interrupt.
  - An interrupt is taken when `i_irq && i_sr_ie` and no synchronous event is present. An interrupt also needs `i_valid_p3`, so the EPC is always a real instruction.
- **On detection:**
  - Latch the cause into `o_cause`.
  - Latch EPC = `i_bd_p3` ? `i_pc_p3` − 4 : `i_pc_p3`, using a 32-bit subtract that wraps modulo 2^32.
  - Latch the vector address.
  - Go to FLUSH.
- **FLUSH** (exactly 1 cycle, regardless of stall): assert `o_drop_p1..p3`, `o_epc_we` and `o_ie_save` for this cycle only, then go to REDIR.
- **REDIR:** hold `o_redir=1` and a stable `o_redir_addr` until `i_redir_ack` is sampled high, then go to IDLE.
- **Busy masking:** all exception and interrupt inputs are ignored outside IDLE; those instructions have been dropped.
- **Arithmetic:** the vector add is 32-bit. The cause-derived offset stays below 1 KiB, so it never carries into the IVT bits.

## Timing
- **Reset:** async to IDLE. `o_drop_p*`, `o_epc_we`, `o_ie_save`, `o_redir` and `o_busy` = 0. `o_epc`, `o_redir_addr` and `o_cause` = 0.
- **Latency:** detection edge E0 → FLUSH pulses in cycle E0+1 → `o_redir` from E0+2. With the ack at E0+2, the block is back in IDLE at E0+3; minimum busy is 2 cycles.
- **Stall:** with `i_core_stall` high in IDLE, nothing is detected; the event is re-evaluated once the stall clears.
- **RFE and interrupt together:** an RFE retiring in the same cycle as a pending interrupt is not special-cased. `i_sr_ie` is a register, so the interrupt can be taken no earlier than the cycle after SR.IE updates.
- **Interrupt deasserted:** if `i_irq` drops during FLUSH/REDIR, the sequence still completes.
- **Ack timing:** an ack arriving while in FLUSH is ignored; only an ack in REDIR counts.
- **Reset mid-sequence:** any state returns to IDLE and all pulses are cleared immediately.

## Structure
- Cause codes and the PRID-independent state encodings go in `cpu_const.vh` (`CPU_EXC_INT`, `CPU_EXC_SYS`, `CPU_EXC_BRK`, `CPU_EXC_RI`).
- The vector width and the 10-bit IVT alignment also go in `cpu_const.vh`.
- One sub-module: `excp_prio`. It is combinational and takes the flags plus irq/ie and produces `take` and a 5-bit cause.
- The FSM, EPC latch and vector latch stay in the top module.

## Test plan
- **Syscall:** `i_sys_p3=1`, valid, PC=0x0000_1000, ivt=0x000001 → FLUSH pulses 1 cycle later; EPC=0x0000_1000; cause=8; redir_addr=0x0000_0440.
- **Simultaneous events:** RI+BRK+irq (ie=1) together → cause=10 and a single sequence; the irq stays pending and is taken after the return to IDLE if still asserted.
- **Delay slot:** `i_bd_p3=1`, PC=0x0000_0000, irq with ie=1 → EPC=0xFFFF_FFFC (wrap); cause=0; redir_addr = IVT base.
- **Stall and IE gating:**
  - irq with ie=0 → no action.
  - irq with ie=1 and `i_core_stall` high for 3 cycles → detection on the first unstalled edge only.
- **Ack delay:** ack withheld 5 cycles → `o_redir` and its address stay stable; exception flags asserted meanwhile are ignored; IDLE one cycle after the ack.
- **Reset:** `nrst` low during REDIR → all outputs 0 asynchronously; IDLE after release.
